// File: rtl/pool_pkg.sv
// ============================================================================
// Module  : pool_pkg
// Brief   : Shared geometry, lane type and serializer FSM states for avg_pool output.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pool_pkg;

  localparam int LANES     = 32;
  localparam int DW        = 32;
  localparam int OUT_LANES = 4;
  localparam int BEATS     = LANES / OUT_LANES;

  typedef logic [DW-1:0] lane_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pool_vec_fifo.sv
// ============================================================================
// Module  : pool_vec_fifo
// Brief   : DEPTH-entry register FIFO of whole vectors; exposes head and the entry behind it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pool_vec_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int                c_PW       = $clog2(DEPTH);
  localparam logic [c_PW-1:0]   c_PTR_ONE  = c_PW'(1);
  localparam logic [c_PW:0]     c_LVL_ONE  = (c_PW + 1)'(1);
  localparam logic [c_PW:0]     c_LVL_FULL = (c_PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_PW:0]    r_level;
  logic [c_PW-1:0]  w_rd_ptr_next;

  // Storage carries no reset: only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({push, pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_rd_ptr_next = r_rd_ptr + c_PTR_ONE;
  assign head_data     = r_mem[r_rd_ptr];
  assign next_data     = r_mem[w_rd_ptr_next];
  assign level         = r_level;
  assign full          = (r_level == c_LVL_FULL);

endmodule

`default_nettype wire

// File: rtl/pool_out_serializer.sv
// ============================================================================
// Module  : pool_out_serializer
// Brief   : Buffers pooled vectors and streams them as OUT_LANES-wide valid/ready beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pool_out_serializer #(
  parameter int LANES     = pool_pkg::LANES,
  parameter int DW        = pool_pkg::DW,
  parameter int OUT_LANES = pool_pkg::OUT_LANES,
  parameter int DEPTH     = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 enable,
  input  logic                                 init,
  input  logic [LANES*DW-1:0]                  in_data,
  input  logic                                 in_data_valid,
  output logic [OUT_LANES*DW-1:0]              out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [$clog2(LANES/OUT_LANES)-1:0]   out_beat,
  output logic [$clog2(DEPTH):0]               level,
  output logic                                 overflow
);

  import pool_pkg::state_t;
  import pool_pkg::IDLE;
  import pool_pkg::SEND;

  localparam int                c_BEATS     = LANES / OUT_LANES;
  localparam int                c_BW        = $clog2(c_BEATS);
  localparam int                c_BEAT_W    = OUT_LANES * DW;
  localparam int                c_VEC_W     = LANES * DW;
  localparam int                c_LW        = $clog2(DEPTH) + 1;
  localparam logic [c_BW-1:0]   c_BEAT_ONE  = c_BW'(1);
  localparam logic [c_BW-1:0]   c_LAST_BEAT = c_BW'(c_BEATS - 1);
  localparam logic [c_LW-1:0]   c_LVL_ONE   = c_LW'(1);
  localparam logic              c_SINGLE    = 1'(c_BEATS == 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [c_BW-1:0]       r_out_beat;
  logic [c_BEAT_W-1:0]   r_out_data;
  logic                  r_overflow;

  logic [c_VEC_W-1:0]    w_head;
  logic [c_VEC_W-1:0]    w_next;
  logic [c_LW-1:0]       w_level;
  logic                  w_full;
  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_more;
  logic [c_BW-1:0]       w_beat_inc;

  logic                  w_load;
  logic                  w_valid_nxt;
  logic                  w_last_nxt;
  logic [c_BW-1:0]       w_beat_nxt;
  logic [c_BW-1:0]       w_src_beat;
  logic [c_VEC_W-1:0]    w_src_vec;
  logic [c_BEAT_W-1:0]   w_beats [c_BEATS];

  assign w_hs       = r_out_valid & out_ready;
  assign w_last_hs  = w_hs & r_out_last;
  assign w_pop      = w_last_hs & ~init;
  // A final-beat handshake frees a slot in the same cycle, so a strobe into a full buffer still lands.
  assign w_push     = in_data_valid & ~init & (~w_full | w_last_hs);
  assign w_drop     = in_data_valid & ~init & w_full & ~w_last_hs;
  assign w_more     = (w_level > c_LVL_ONE) | w_push;
  assign w_beat_inc = r_out_beat + c_BEAT_ONE;

  pool_vec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_VEC_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (init),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (in_data),
    .head_data (w_head),
    .next_data (w_next),
    .level     (w_level),
    .full      (w_full)
  );

  for (genvar b = 0; b < c_BEATS; b++) begin : g_beat
    assign w_beats[b] = w_src_vec[b*c_BEAT_W +: c_BEAT_W];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (init) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if ((w_level != '0) && enable) w_state_nxt = SEND;
        SEND:    if (w_last_hs && !(w_more && enable)) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // The vector that follows a final beat is either the second FIFO entry or the strobe arriving now.
  always_comb begin
    w_load      = 1'b0;
    w_valid_nxt = r_out_valid;
    w_last_nxt  = r_out_last;
    w_beat_nxt  = r_out_beat;
    w_src_beat  = '0;
    w_src_vec   = w_head;
    case (r_state)
      IDLE: begin
        if ((w_level != '0) && enable) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_beat_nxt  = '0;
          w_last_nxt  = c_SINGLE;
        end
      end
      SEND: begin
        if (w_last_hs) begin
          w_beat_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_valid_nxt = 1'b0;
          if (w_more && enable) begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
            w_last_nxt  = c_SINGLE;
            w_src_vec   = (w_level > c_LVL_ONE) ? w_next : in_data;
          end
        end else if (w_hs) begin
          w_load      = 1'b1;
          w_src_beat  = w_beat_inc;
          w_beat_nxt  = w_beat_inc;
          w_last_nxt  = (w_beat_inc == c_LAST_BEAT);
          w_valid_nxt = enable;
        end else if (!r_out_valid && enable) begin
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_beat  <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else if (init) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_beat  <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
      r_out_beat  <= w_beat_nxt;
      if (w_load) r_out_data <= w_beats[w_src_beat];
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_beat  = r_out_beat;
  assign level     = w_level;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pool_out_serializer.sv
// ============================================================================
// Module  : tb_pool_out_serializer
// Brief   : Directed scenarios plus random traffic against a queue-based vector/beat model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pool_out_serializer;
  import pool_pkg::*;

  localparam int TB_DEPTH = 2;
  localparam int VEC_W    = LANES * DW;
  localparam int BEAT_W   = OUT_LANES * DW;

  logic                            clk;
  logic                            rstn;
  logic                            enable;
  logic                            init;
  logic [VEC_W-1:0]                in_data;
  logic                            in_data_valid;
  logic [BEAT_W-1:0]               out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic [$clog2(BEATS)-1:0]        out_beat;
  logic [$clog2(TB_DEPTH):0]       level;
  logic                            overflow;

  int n_cmp = 0;
  int n_mis = 0;

  pool_out_serializer #(
    .LANES     (LANES),
    .DW        (DW),
    .OUT_LANES (OUT_LANES),
    .DEPTH     (TB_DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .init          (init),
    .in_data       (in_data),
    .in_data_valid (in_data_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_beat      (out_beat),
    .level         (level),
    .overflow      (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic drain(input string tag);
    enable = 1'b1; out_ready = 1'b1; in_data_valid = 1'b0; init = 1'b0;
    for (int i = 0; i < 100 && (level != 0 || out_valid); i++) step();
    chk({tag, "_level"}, level, 0);
    chk({tag, "_valid"}, out_valid, 0);
  endtask

  // Reference model: accepted vectors in order, beats consumed of the head, sticky drop flag.
  logic [VEC_W-1:0]  m_q[$];
  logic [VEC_W-1:0]  m_vec;
  int                m_bcnt;
  logic              m_ovf;
  logic              p_hold, p_en, p_init;
  logic [BEAT_W-1:0] p_data;
  logic [2:0]        p_beat;
  logic              m_hs, m_last_hs, m_accept;

  always begin
    @(negedge clk); #4;
    if (!rstn) begin
      m_q.delete(); m_bcnt = 0; m_ovf = 1'b0;
      p_hold = 1'b0; p_en = 1'b1; p_init = 1'b0;
    end else begin
      if (p_init || (!p_en && !p_hold)) chk("no_launch", out_valid, 0);
      if (p_hold && !p_init) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, p_data);
        chk("hold_beat", out_beat, p_beat);
      end
      chk("level", level, m_q.size());
      chk("overflow", overflow, m_ovf);
      m_hs = out_valid && out_ready;
      m_last_hs = 1'b0;
      if (m_hs) begin
        if (m_q.size() == 0) begin
          chk("beat_unexpected", out_valid, 0);
        end else begin
          m_vec = m_q[0];
          chk("beat_data", out_data, m_vec[m_bcnt*BEAT_W +: BEAT_W]);
          chk("beat_idx", out_beat, m_bcnt);
          chk("beat_last", out_last, (m_bcnt == BEATS-1));
          m_last_hs = (m_bcnt == BEATS-1);
        end
      end
      p_hold = out_valid && !out_ready;
      p_data = out_data;
      p_beat = out_beat;
      p_en   = enable;
      p_init = init;
      if (init) begin
        m_q.delete(); m_bcnt = 0; m_ovf = 1'b0;
      end else begin
        m_accept = in_data_valid && (m_q.size() < TB_DEPTH || m_last_hs);
        if (m_hs && m_q.size() > 0) begin
          if (m_last_hs) begin
            void'(m_q.pop_front());
            m_bcnt = 0;
          end else begin
            m_bcnt++;
          end
        end
        if (m_accept) m_q.push_back(in_data);
        else if (in_data_valid) m_ovf = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VEC_W-1:0] v1;
    int nhs;
    rstn = 1'b0; enable = 1'b0; init = 1'b0; in_data = '0; in_data_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    rstn = 1'b1;
    step();

    // Single vector, lane k = 0x100+k, streamed at full rate.
    for (int k = 0; k < LANES; k++) v1[k*DW +: DW] = 32'h100 + k;
    enable = 1'b1; out_ready = 1'b1; in_data = v1; in_data_valid = 1'b1;
    step();
    in_data_valid = 1'b0;
    chk("t1_lat_level", level, 1);
    chk("t1_lat_valid", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_beat0", out_data, 128'h00000103_00000102_00000101_00000100);
    for (int b = 0; b < BEATS; b++) begin
      chk("t1_beat", out_beat, b);
      chk("t1_last", out_last, (b == BEATS-1));
      step();
    end
    chk("t1_done_valid", out_valid, 0);
    chk("t1_done_level", level, 0);

    // Same vector with ready pattern 1,0,0.
    out_ready = 1'b0; in_data = v1; in_data_valid = 1'b1;
    step();
    in_data_valid = 1'b0;
    nhs = 0;
    for (int i = 0; i < 60 && nhs < BEATS; i++) begin
      out_ready = (i % 3 == 0);
      if (out_valid && out_ready) begin
        chk("t2_beat", out_beat, nhs);
        nhs++;
      end
      step();
    end
    chk("t2_count", nhs, BEATS);
    step();
    chk("t2_idle", out_valid, 0);

    // Three strobes into a stalled two-deep buffer.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = rand_vec(); in_data_valid = 1'b1;
      step();
    end
    in_data_valid = 1'b0;
    chk("t3_level", level, 2);
    chk("t3_ovf", overflow, 1);
    out_ready = 1'b1; nhs = 0;
    for (int i = 0; i < 60 && nhs < 2*BEATS; i++) begin
      if (out_valid) nhs++;
      step();
    end
    chk("t3_count", nhs, 2*BEATS);
    chk("t3_level_end", level, 0);
    chk("t3_ovf_sticky", overflow, 1);

    // Strobe into a full buffer on the head's final beat.
    init = 1'b1;
    step();
    init = 1'b0;
    chk("t4_init_ovf", overflow, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = rand_vec(); in_data_valid = 1'b1;
      step();
    end
    in_data_valid = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !(out_valid && out_beat == 3'd7); i++) step();
    chk("t4_reach", (out_valid && out_beat == 3'd7), 1);
    in_data = rand_vec(); in_data_valid = 1'b1;
    step();
    in_data_valid = 1'b0;
    chk("t4_level", level, 2);
    chk("t4_ovf", overflow, 0);
    chk("t4_nobubble", out_valid, 1);
    chk("t4_beat", out_beat, 0);
    drain("t4_drain");

    // Flush mid-vector with a queued vector and overflow set.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = rand_vec(); in_data_valid = 1'b1;
      step();
    end
    in_data_valid = 1'b0;
    chk("t5_ovf_set", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !(out_valid && out_beat == 3'd3); i++) step();
    chk("t5_reach", (out_valid && out_beat == 3'd3), 1);
    init = 1'b1;
    step();
    init = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_level", level, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_beat", out_beat, 0);
    in_data = rand_vec(); in_data_valid = 1'b1;
    step();
    in_data_valid = 1'b0;
    step();
    chk("t5_restart_valid", out_valid, 1);
    chk("t5_restart_beat", out_beat, 0);
    drain("t5_drain");

    // Asynchronous reset while a beat is presented with enable low.
    out_ready = 1'b0; in_data = rand_vec(); in_data_valid = 1'b1;
    step();
    in_data_valid = 1'b0;
    step();
    chk("t6_pre_valid", out_valid, 1);
    enable = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_beat", out_beat, 0);
    repeat (5) step();
    rstn = 1'b1;
    step();
    in_data = rand_vec(); in_data_valid = 1'b1;
    step();
    in_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t6_held_valid", out_valid, 0);
      chk("t6_held_level", level, 1);
      step();
    end
    enable = 1'b1;
    step();
    chk("t6_go_valid", out_valid, 1);
    chk("t6_go_beat", out_beat, 0);
    drain("t6_drain");

    // Random traffic, checked entirely by the model.
    for (int c = 0; c < 1500; c++) begin
      enable        = ($urandom_range(0, 99) < 85);
      out_ready     = ($urandom_range(0, 99) < 70);
      init          = ($urandom_range(0, 299) == 0);
      in_data_valid = ($urandom_range(0, 5) == 0);
      in_data       = rand_vec();
      step();
    end
    drain("rand_drain");
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
